// File: rtl/axi_ar_arb2.sv
// rtl/axi_ar_arb2.sv - two-port AXI4 read arbiter with outstanding caps and starvation guard
module axi_ar_arb2 #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic              s0_arid,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic              s1_arid,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [1:0]        M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic              M_AXI_ARLOCK,
  output logic [2:0]        M_AXI_ARPROT,
  output logic [3:0]        M_AXI_ARQOS,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [1:0]        M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic              err_o
);

  localparam int CW = 4;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt0, cnt1;
  logic [SW-1:0]   starve;
  logic            elig0, elig1, win0, win1;
  logic            grant0, grant1;
  logic            ar_hs, r_last_hs, r_src;
  logic            unused_rid0;

  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign unused_rid0   = M_AXI_RID[0];

  // Eligibility and winner selection; port 1 only wins a contested slot once starved
  always_comb begin
    elig0 = s0_arvalid && (cnt0 < CW'(MAX_OUT));
    elig1 = s1_arvalid && (cnt1 < CW'(MAX_OUT));
    win1  = elig1 && (!elig0 || (starve == SW'(STARVE_MAX)));
    win0  = elig0 && !win1;
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next state and the one-cycle accept pulses; nothing is granted while reset is held
  always_comb begin
    state_n = state;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          grant0 = win0;
          grant1 = win1;
          if (win0 || win1) state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (M_AXI_ARREADY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign s0_arready = grant0;
  assign s1_arready = grant1;
  assign ar_hs      = M_AXI_ARVALID && M_AXI_ARREADY;

  // AR channel registers: captured on a grant, held until the master accepts
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARID    <= '0;
    end else if (grant0 || grant1) begin
      M_AXI_ARVALID <= 1'b1;
      M_AXI_ARADDR  <= grant1 ? s1_araddr : s0_araddr;
      M_AXI_ARLEN   <= grant1 ? s1_arlen : s0_arlen;
      M_AXI_ARID    <= grant1 ? {1'b1, s1_arid} : {1'b0, s0_arid};
    end else if (ar_hs) begin
      M_AXI_ARVALID <= 1'b0;
    end
  end

  // Starvation counter: counts port-0 wins that passed over a waiting port 1
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (grant1) begin
      starve <= '0;
    end else if (grant0 && s1_arvalid && (starve != SW'(STARVE_MAX))) begin
      starve <= starve + 1'b1;
    end
  end

  // R path: route by the source bit of RID, data and last are broadcast
  always_comb begin
    r_src        = M_AXI_RID[1];
    M_AXI_RREADY = r_src ? s1_rready : s0_rready;
    s0_rvalid    = M_AXI_RVALID && !r_src;
    s1_rvalid    = M_AXI_RVALID && r_src;
    s0_rdata     = M_AXI_RDATA;
    s1_rdata     = M_AXI_RDATA;
    s0_rlast     = M_AXI_RLAST;
    s1_rlast     = M_AXI_RLAST;
    r_last_hs    = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;
  end

  // Outstanding burst counters; a last beat with nothing outstanding flags a sticky error
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      cnt0  <= '0;
      cnt1  <= '0;
      err_o <= 1'b0;
    end else begin
      if (ar_hs && !M_AXI_ARID[1] && !(r_last_hs && !r_src)) begin
        cnt0 <= cnt0 + 1'b1;
      end else if (r_last_hs && !r_src && !(ar_hs && !M_AXI_ARID[1])) begin
        if (cnt0 == '0) err_o <= 1'b1;
        else            cnt0  <= cnt0 - 1'b1;
      end
      if (ar_hs && M_AXI_ARID[1] && !(r_last_hs && r_src)) begin
        cnt1 <= cnt1 + 1'b1;
      end else if (r_last_hs && r_src && !(ar_hs && M_AXI_ARID[1])) begin
        if (cnt1 == '0) err_o <= 1'b1;
        else            cnt1  <= cnt1 - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_arb2.sv
// tb/tb_axi_ar_arb2.sv - self-checking bench for axi_ar_arb2
module tb_axi_ar_arb2;

  logic        clk_i = 1'b0;
  logic        reset;
  logic [28:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic        s0_arid, s1_arid, s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [1:0]  M_AXI_ARID;
  logic [28:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic        M_AXI_ARLOCK;
  logic [2:0]  M_AXI_ARPROT;
  logic [3:0]  M_AXI_ARQOS;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [1:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int win_log[$];

  axi_ar_arb2 dut (
    .clk_i(clk_i), .reset(reset),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arid(s0_arid),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arid(s1_arid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s0_arvalid = 0; s1_arvalid = 0; s0_araddr = '0; s1_araddr = '0;
    s0_arlen = '0; s1_arlen = '0; s0_arid = 0; s1_arid = 0;
    M_AXI_ARREADY = 0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RLAST = 0;
    M_AXI_RVALID = 0; s0_rready = 0; s1_rready = 0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1;
    idle_inputs();
    repeat (2) cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1;
    s0_arvalid = 1;
    s1_arvalid = 1;
    @(negedge clk_i);
    n_checks++;
    if (s0_arready !== 0 || s1_arready !== 0) begin
      n_fail++; $display("FAIL reset_arready: got %b%b want 00", s0_arready, s1_arready);
    end
    n_checks++;
    if (M_AXI_ARVALID !== 0 || M_AXI_ARADDR !== 0 || M_AXI_ARLEN !== 0 || M_AXI_ARID !== 0) begin
      n_fail++; $display("FAIL reset_ar: got v=%b a=%h l=%h id=%b want zeros",
                         M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARID);
    end
    n_checks++;
    if (err_o !== 0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_checks++;
    if (M_AXI_ARSIZE !== 3'b010 || M_AXI_ARBURST !== 2'b01 || M_AXI_ARCACHE !== 4'b0011 ||
        M_AXI_ARLOCK !== 0 || M_AXI_ARPROT !== 0 || M_AXI_ARQOS !== 0) begin
      n_fail++; $display("FAIL const_fields: got size=%b burst=%b cache=%b", M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE);
    end
    s0_arvalid = 0;
    s1_arvalid = 0;
    cyc();
    reset = 0;
  endtask

  task automatic test_port0_burst();
    int held = 0;
    logic [31:0] d;
    cyc();
    s0_araddr = 29'h0ABCDE0; s0_arlen = 8'd255; s0_arid = 0; s0_arvalid = 1; M_AXI_ARREADY = 0;
    @(negedge clk_i);
    n_checks++;
    if (s0_arready !== 1 || s1_arready !== 0) begin
      n_fail++; $display("FAIL p0_grant: got %b%b want 10", s0_arready, s1_arready);
    end
    cyc();
    s0_arvalid = 0;
    s0_araddr = '1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      M_AXI_ARREADY = (k == 2);
      @(negedge clk_i);
      if (M_AXI_ARVALID === 1) held++;
      n_checks++;
      if (M_AXI_ARID !== 2'b00 || M_AXI_ARADDR !== 29'h0ABCDE0 || M_AXI_ARLEN !== 8'd255) begin
        n_fail++; $display("FAIL p0_fields: got id=%b a=%h l=%0d want 00 0abcde0 255",
                           M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN);
      end
    end
    cyc();
    M_AXI_ARREADY = 0;
    @(negedge clk_i);
    n_checks++;
    if (held != 3 || M_AXI_ARVALID !== 0) begin
      n_fail++; $display("FAIL p0_hold: got held=%0d v=%b want 3 0", held, M_AXI_ARVALID);
    end
    s0_rready = 1; s1_rready = 0;
    for (int b = 0; b < 256; b++) begin
      cyc();
      d = $urandom;
      M_AXI_RVALID = 1; M_AXI_RID = 2'b00; M_AXI_RDATA = d; M_AXI_RLAST = (b == 255);
      @(negedge clk_i);
      n_checks++;
      if (s0_rvalid !== 1 || s1_rvalid !== 0 || s0_rdata !== d || s0_rlast !== (b == 255) ||
          M_AXI_RREADY !== 1) begin
        n_fail++; $display("FAIL p0_beat%0d: got v=%b%b d=%h rdy=%b want 10 %h 1",
                           b, s0_rvalid, s1_rvalid, s0_rdata, M_AXI_RREADY, d);
      end
    end
    cyc();
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 0) begin n_fail++; $display("FAIL p0_err: got %b want 0", err_o); end
  endtask

  task automatic test_outstanding_cap();
    int g = 0;
    M_AXI_ARREADY = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      s0_arvalid = 1;
      s0_araddr = 29'($urandom);
      @(negedge clk_i);
      if (s0_arready === 1) g++;
    end
    n_checks++;
    if (g != 4) begin n_fail++; $display("FAIL cap_p0: got %0d grants want 4", g); end
    cyc();
    s1_arvalid = 1; s1_arid = 1;
    @(negedge clk_i);
    n_checks++;
    if (s1_arready !== 1 || s0_arready !== 0) begin
      n_fail++; $display("FAIL cap_p1_grant: got %b%b want 01", s0_arready, s1_arready);
    end
    cyc();
    s0_arvalid = 0; s1_arvalid = 0;
    @(negedge clk_i);
    n_checks++;
    if (M_AXI_ARVALID !== 1 || M_AXI_ARID !== 2'b11) begin
      n_fail++; $display("FAIL cap_p1_id: got v=%b id=%b want 1 11", M_AXI_ARVALID, M_AXI_ARID);
    end
    cyc();
  endtask

  task automatic test_same_cycle();
    int g = 0;
    s0_rready = 1;
    for (int i = 0; i < 2; i++) begin
      cyc(); M_AXI_RVALID = 1; M_AXI_RID = 2'b00; M_AXI_RLAST = 1;
    end
    cyc();
    M_AXI_RVALID = 0; s0_arvalid = 1; M_AXI_ARREADY = 1;
    @(negedge clk_i);
    n_checks++;
    if (s0_arready !== 1) begin n_fail++; $display("FAIL same_grant: got %b want 1", s0_arready); end
    cyc();
    s0_arvalid = 0; M_AXI_RVALID = 1; M_AXI_RID = 2'b00; M_AXI_RLAST = 1;
    @(negedge clk_i);
    n_checks++;
    if (M_AXI_ARVALID !== 1 || M_AXI_RREADY !== 1) begin
      n_fail++; $display("FAIL same_overlap: got v=%b rr=%b want 1 1", M_AXI_ARVALID, M_AXI_RREADY);
    end
    cyc();
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      s0_arvalid = 1;
      @(negedge clk_i);
      if (s0_arready === 1) g++;
    end
    n_checks++;
    if (g != 2) begin n_fail++; $display("FAIL same_cnt: got %0d grants want 2", g); end
    cyc();
    s0_arvalid = 0;
  endtask

  task automatic test_err();
    cyc();
    M_AXI_RVALID = 1; M_AXI_RID = 2'b10; M_AXI_RLAST = 1; s1_rready = 1; s0_rready = 0;
    @(negedge clk_i);
    n_checks++;
    if (s1_rvalid !== 1 || s0_rvalid !== 0 || M_AXI_RREADY !== 1) begin
      n_fail++; $display("FAIL err_route: got v=%b%b rr=%b want 01 1", s0_rvalid, s1_rvalid, M_AXI_RREADY);
    end
    cyc();
    M_AXI_RVALID = 0;
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 0) begin n_fail++; $display("FAIL err_early: got %b want 0", err_o); end
    cyc();
    M_AXI_RVALID = 1;
    cyc();
    M_AXI_RVALID = 0;
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_o); end
    repeat (3) cyc();
    s1_arvalid = 1;
    @(negedge clk_i);
    n_checks++;
    if (err_o !== 1 || s1_arready !== 1) begin
      n_fail++; $display("FAIL err_sticky: got err=%b g1=%b want 1 1", err_o, s1_arready);
    end
    cyc();
    s1_arvalid = 0;
    cyc();
  endtask

  task automatic test_reset_mid_issue();
    int g = 0;
    cyc();
    M_AXI_ARREADY = 0; s1_arvalid = 1;
    @(negedge clk_i);
    cyc();
    s1_arvalid = 0;
    @(negedge clk_i);
    n_checks++;
    if (M_AXI_ARVALID !== 1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", M_AXI_ARVALID); end
    #2 reset = 1;
    #1;
    n_checks++;
    if (M_AXI_ARVALID !== 0 || err_o !== 0) begin
      n_fail++; $display("FAIL mid_async: got v=%b err=%b want 0 0", M_AXI_ARVALID, err_o);
    end
    cyc(); cyc();
    reset = 0;
    M_AXI_ARREADY = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      s0_arvalid = 1;
      @(negedge clk_i);
      if (s0_arready === 1) g++;
    end
    n_checks++;
    if (g != 4) begin n_fail++; $display("FAIL mid_cnt_clear: got %0d grants want 4", g); end
    s0_arvalid = 0;
  endtask

  task automatic test_traffic(input int ncyc, input bit forced);
    int mcnt[2];
    int mst = 0;
    bit busy = 0;
    logic [1:0] e_id = '0;
    logic [28:0] e_addr = '0;
    logic [7:0] e_len = '0;
    logic [1:0] q_id[$];
    int q_len[$];
    int beat = 0;
    bit e0, e1, w0, w1, sel_rdy, r_hs, ar_hs;
    int bad = 0;
    mcnt[0] = 0; mcnt[1] = 0;
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      s0_arvalid = forced ? 1'b1 : 1'($urandom % 2);
      s1_arvalid = forced ? 1'b1 : 1'($urandom % 2);
      s0_araddr = 29'($urandom); s1_araddr = 29'($urandom);
      s0_arlen = forced ? 8'd0 : 8'($urandom % 4);
      s1_arlen = forced ? 8'd0 : 8'($urandom % 4);
      s0_arid = 1'($urandom); s1_arid = 1'($urandom);
      M_AXI_ARREADY = forced ? 1'b1 : ($urandom % 3 != 0);
      s0_rready = forced ? 1'b1 : 1'($urandom % 2);
      s1_rready = forced ? 1'b1 : 1'($urandom % 2);
      M_AXI_RDATA = $urandom;
      if (q_id.size() > 0 && (forced || ($urandom % 2 == 0))) begin
        M_AXI_RVALID = 1; M_AXI_RID = q_id[0]; M_AXI_RLAST = (beat == q_len[0]);
      end else begin
        M_AXI_RVALID = 0; M_AXI_RID = 2'($urandom); M_AXI_RLAST = 1'($urandom);
      end
      @(negedge clk_i);
      e0 = s0_arvalid && mcnt[0] < 4;
      e1 = s1_arvalid && mcnt[1] < 4;
      w1 = !busy && e1 && (!e0 || mst == 8);
      w0 = !busy && e0 && !w1;
      n_checks++;
      if (s0_arready !== w0 || s1_arready !== w1 || M_AXI_ARVALID !== busy) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL traffic_grant c=%0d: got g=%b%b v=%b want %b%b %b",
                               c, s0_arready, s1_arready, M_AXI_ARVALID, w0, w1, busy);
      end
      if (busy) begin
        n_checks++;
        if (M_AXI_ARID !== e_id || M_AXI_ARADDR !== e_addr || M_AXI_ARLEN !== e_len) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL traffic_fields c=%0d: got %b %h %0d want %b %h %0d",
                                 c, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, e_id, e_addr, e_len);
        end
      end
      sel_rdy = M_AXI_RID[1] ? s1_rready : s0_rready;
      n_checks++;
      if (s0_rvalid !== (M_AXI_RVALID && !M_AXI_RID[1]) || s1_rvalid !== (M_AXI_RVALID && M_AXI_RID[1]) ||
          M_AXI_RREADY !== sel_rdy || s1_rdata !== M_AXI_RDATA || err_o !== 0) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL traffic_r c=%0d: got v=%b%b rr=%b err=%b want rr=%b err=0",
                               c, s0_rvalid, s1_rvalid, M_AXI_RREADY, err_o, sel_rdy);
      end
      r_hs  = M_AXI_RVALID && sel_rdy;
      ar_hs = busy && M_AXI_ARREADY;
      if (r_hs && M_AXI_RLAST) begin
        mcnt[M_AXI_RID[1]]--;
        void'(q_id.pop_front()); void'(q_len.pop_front());
        beat = 0;
      end else if (r_hs) begin
        beat++;
      end
      if (ar_hs) begin
        mcnt[e_id[1]]++;
        q_id.push_back(e_id); q_len.push_back(int'(e_len));
        busy = 0;
      end else if (w0 || w1) begin
        busy = 1;
        e_id   = w1 ? {1'b1, s1_arid} : {1'b0, s0_arid};
        e_addr = w1 ? s1_araddr : s0_araddr;
        e_len  = w1 ? s1_arlen : s0_arlen;
        win_log.push_back(w1 ? 1 : 0);
        if (w1) mst = 0;
        else if (s1_arvalid && mst < 8) mst++;
      end
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_starve();
    do_reset();
    win_log.delete();
    test_traffic(80, 1'b1);
    n_checks++;
    if (win_log.size() < 30) begin
      n_fail++; $display("FAIL starve_count: got %0d grants want >=30", win_log.size());
    end
    for (int k = 0; k < win_log.size(); k++) begin
      n_checks++;
      if (win_log[k] != ((k % 9 == 8) ? 1 : 0)) begin
        n_fail++; $display("FAIL starve_seq k=%0d: got port %0d want port %0d", k, win_log[k], (k % 9 == 8) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    win_log.delete();
    test_traffic(3000, 1'b0);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_port0_burst();
    test_outstanding_cap();
    test_same_cycle();
    test_err();
    test_reset_mid_issue();
    test_starve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
